// File: rtl/subtrator_serial_8bits_pkg.sv
// Shared types and constants for the bit-serial signed subtractor.
package subtrator_serial_8bits_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Subtraction is A + ~B + 1, so the serial carry starts at one.
  localparam logic CARRY_INIT = 1'b1;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/somador_completo_1bit.sv
// One-bit full adder; the only arithmetic cell of the serial subtractor.
module somador_completo_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/subtrator_serial_8bits.sv
// Bit-serial signed subtractor D = valor1 - valor2, LSB first, with a
// start/busy/done handshake and Z/N/P/V flags registered at completion.
module subtrator_serial_8bits
  import subtrator_serial_8bits_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] valor1,
  input  logic [WIDTH-1:0] valor2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Z,
  output logic             N,
  output logic             P,
  output logic             V
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, r_reg, r_next;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next, sum;
  logic             sign_a, sign_b;
  logic             last_bit, accept;

  somador_completo_1bit u_fa (
    .a    (a_reg[0]),
    .b    (~b_reg[0]),
    .cin  (carry),
    .s    (sum),
    .cout (carry_next)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // A request is honoured only when no operation is in flight.
  assign accept   = start && (state != SHIFT);
  assign r_next   = {sum, r_reg[WIDTH-1:1]};

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, e.g. a_reg[0] feeding the adder
  // while a_reg itself shifts on the same edge.
  // NOTE: the operand and result registers are plain flops rather than a
  // memory array, and all of them are cleared so an aborted operation
  // leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (accept) begin
      a_reg  <= valor1;
      b_reg  <= valor2;
      r_reg  <= '0;
      cnt    <= '0;
      carry  <= CARRY_INIT;
      sign_a <= valor1[WIDTH-1];
      sign_b <= valor2[WIDTH-1];
    end else if (state == SHIFT) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      r_reg <= r_next;
      carry <= carry_next;
      cnt   <= cnt + CW'(1);
    end
  end

  // Results are captured from the final shift value so they appear on the
  // same edge that enters DONE; they hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D <= '0;
      Z <= 1'b0;
      N <= 1'b0;
      P <= 1'b0;
      V <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      D <= r_next;
      Z <= (r_next == '0);
      N <= sum;
      P <= ~r_next[0];
      V <= (sign_a ^ sign_b) & (sum ^ sign_a);
    end
  end

endmodule

// File: tb/tb_subtrator_serial_8bits.sv
// Self-checking bench for subtrator_serial_8bits: directed corner cases plus
// randomized operands against a plain signed-arithmetic reference.
module tb_subtrator_serial_8bits;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] valor1 = '0;
  logic [W-1:0] valor2 = '0;
  logic         busy, done, Z, N, P, V;
  logic [W-1:0] D;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_prev_d = '0;

  subtrator_serial_8bits #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .valor1 (valor1),
    .valor2 (valor2),
    .busy   (busy),
    .done   (done),
    .D      (D),
    .Z      (Z),
    .N      (N),
    .P      (P),
    .V      (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: true signed difference, then wrap to W bits.
  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int           diff;
    logic [31:0]  dw;
    logic [W-1:0] d;
    diff = int'($signed(a)) - int'($signed(b));
    dw   = diff;
    d    = dw[W-1:0];
    check({tag, ".D"}, D, d);
    check({tag, ".Z"}, Z, d == 0);
    check({tag, ".N"}, N, d[W-1]);
    check({tag, ".P"}, P, !d[0]);
    check({tag, ".V"}, V, (diff > 127) || (diff < -128));
    exp_prev_d = d;
  endtask

  // Counts negedges until done is seen; D must not move while busy.
  task automatic wait_done(input int budget, output int cycles, output int busy_n, output bit ok);
    ok = 0; busy_n = 0; cycles = 0;
    while (cycles < budget && !ok) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_n++;
      if (busy && cycles == 4) check("hold_D_in_shift", D, exp_prev_d);
      if (done) ok = 1;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, bsy;
    bit ok;
    @(negedge clk);
    start = 1'b1; valor1 = a; valor2 = b;
    @(negedge clk);
    start = 1'b0;
    valor1 = W'($urandom); valor2 = W'($urandom);
    check({tag, ".busy_first"}, busy, 1'b1);
    wait_done(20, cyc, bsy, ok);
    check({tag, ".done_seen"}, ok, 1'b1);
    check({tag, ".latency"}, cyc + 1, W + 1);
    check({tag, ".busy_cycles"}, bsy + 1, W);
    check({tag, ".busy_at_done"}, busy, 1'b0);
    check_result(tag, a, b);
    @(negedge clk);
    check({tag, ".done_single"}, done, 1'b0);
    check({tag, ".D_after"}, D, exp_prev_d);
  endtask

  initial begin
    int cyc, bsy, dones;
    bit ok;
    logic [W-1:0] d_at_done;

    repeat (2) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.D", D, 0);
    check("rst.ZNPV", {Z, N, P, V}, 4'b0000);
    rst_n = 1'b1;

    do_op("5-3", 8'd5, 8'd3);
    do_op("3-5", 8'd3, 8'd5);
    do_op("7-7", 8'd7, 8'd7);
    do_op("m128-1", 8'h80, 8'h01);
    do_op("127-m1", 8'h7F, 8'hFF);

    // Second request during SHIFT must be ignored.
    @(negedge clk);
    start = 1'b1; valor1 = 8'd10; valor2 = 8'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; valor1 = 8'd50; valor2 = 8'd1;
    @(negedge clk); start = 1'b0;
    dones = 0; d_at_done = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin dones++; d_at_done = D; end
      @(negedge clk);
    end
    check("ignore.dones", dones, 1);
    check("ignore.D", d_at_done, 8'd6);
    exp_prev_d = 8'd6;

    // Start held high: back-to-back operations every W+1 cycles.
    @(negedge clk);
    start = 1'b1; valor1 = 8'd20; valor2 = 8'd5;
    @(negedge clk);
    valor1 = 8'd1; valor2 = 8'd2;
    wait_done(20, cyc, bsy, ok);
    check("held1.done_seen", ok, 1'b1);
    check("held1.latency", cyc + 1, W + 1);
    check_result("held1", 8'd20, 8'd5);
    @(negedge clk);
    start = 1'b0;
    check("held.busy_again", busy, 1'b1);
    check("held.D_stable", D, 8'd15);
    wait_done(20, cyc, bsy, ok);
    check("held2.done_seen", ok, 1'b1);
    check("held2.period", cyc + 1, W + 1);
    check_result("held2", 8'd1, 8'd2);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1; valor1 = 8'd33; valor2 = 8'd77;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.done", done, 0);
    check("abort.D", D, 0);
    check("abort.ZNPV", {Z, N, P, V}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_prev_d = '0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort.no_activity", dones, 0);
    do_op("9-9", 8'd9, 8'd9);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", W'($urandom), W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
